// File: rtl/ac97_pkg.sv
// Shared widths, TAG bit positions, sequencer state and slot encoders for the AC'97 command path.
package ac97_pkg;

    localparam int SLOT_W = 20;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    localparam int TAG_CODEC_READY = 15;
    localparam int TAG_SLOT1       = 14;
    localparam int TAG_SLOT2       = 13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        RESP     = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Bit 19 of the command address slot is the read flag.
    function automatic logic [SLOT_W-1:0] slot1_encode(input logic rw, input logic [ADDR_W-1:0] addr);
        return {rw, addr, 12'h000};
    endfunction

    function automatic logic [SLOT_W-1:0] slot2_encode(input logic [DATA_W-1:0] data);
        return {data, 4'h0};
    endfunction

endpackage

// File: rtl/ac97_cmd_fifo.sv
// Synchronous command FIFO with registered level; full/empty decode from the level so
// a push is never visible to the reader in the cycle it lands.
module ac97_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ac97_cmd_sequencer.sv
// Queued AC'97 register-access engine: issues one command per frame on output slots 1/2,
// tracks a single outstanding read with timeout/retry and returns it on a valid/ready channel.
module ac97_cmd_sequencer
    import ac97_pkg::*;
#(
    parameter int CMD_DEPTH      = 8,
    parameter int TIMEOUT_FRAMES = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                       ac97_bitclk,
    input  logic                       ac97_rst,
    input  logic                       ac97_strobe,
    input  logic                       ac97_codec_ready,
    input  logic                       ac97_in_slot1_valid,
    input  logic [SLOT_W-1:0]          ac97_in_slot1,
    input  logic                       ac97_in_slot2_valid,
    input  logic [SLOT_W-1:0]          ac97_in_slot2,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ADDR_W-1:0]          rsp_addr,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_timeout,
    output logic [SLOT_W-1:0]          ac97_out_slot1,
    output logic                       ac97_out_slot1_valid,
    output logic [SLOT_W-1:0]          ac97_out_slot2,
    output logic                       ac97_out_slot2_valid,
    output logic [$clog2(CMD_DEPTH):0] fifo_level,
    output logic                       busy
);

    localparam int FRAME_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [FRAME_W-1:0] TIMEOUT_C = FRAME_W'(TIMEOUT_FRAMES);
    localparam logic [RETRY_W-1:0] RETRIES_C = RETRY_W'(MAX_RETRIES);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [ADDR_W-1:0]  r_rsp_addr;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_timeout;
    logic [SLOT_W-1:0]  r_slot1;
    logic               r_slot1_v;
    logic [SLOT_W-1:0]  r_slot2;
    logic               r_slot2_v;

    cmd_t               w_cmd_in;
    cmd_t               w_head;
    logic [CMD_W-1:0]   w_head_bits;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_match;
    logic               w_expired;
    logic               w_retry;
    logic               w_give_up;
    logic [FRAME_W-1:0] w_frame_inc;
    logic [SLOT_W-1:0]  w_slot1_next;
    logic               w_slot1_v_next;
    logic [SLOT_W-1:0]  w_slot2_next;
    logic               w_slot2_v_next;

    assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
    assign w_head   = cmd_t'(w_head_bits);

    ac97_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (ac97_bitclk),
        .i_rst   (ac97_rst),
        .i_push  (cmd_valid),
        .i_din   (w_cmd_in),
        .i_pop   (w_pop),
        .o_dout  (w_head_bits),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign w_match     = ac97_in_slot1_valid && ac97_in_slot2_valid &&
                         (ac97_in_slot1[SLOT_W-2 -: ADDR_W] == r_pend_addr);
    assign w_frame_inc = r_frame_cnt + 1'b1;
    assign w_expired   = (w_frame_inc == TIMEOUT_C);

    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_pop && !w_head.write) w_state_next = WAIT_RSP;
            WAIT_RSP: if (ac97_strobe && (w_match || w_give_up)) w_state_next = RESP;
            RESP:     if (rsp_ready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_pop          = 1'b0;
        w_retry        = 1'b0;
        w_give_up      = 1'b0;
        w_slot1_next   = '0;
        w_slot1_v_next = 1'b0;
        w_slot2_next   = '0;
        w_slot2_v_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (ac97_strobe && !w_fifo_empty && ac97_codec_ready) begin
                    w_pop          = 1'b1;
                    w_slot1_next   = slot1_encode(!w_head.write, w_head.addr);
                    w_slot1_v_next = 1'b1;
                    if (w_head.write) begin
                        w_slot2_next   = slot2_encode(w_head.data);
                        w_slot2_v_next = 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (ac97_strobe && !w_match && w_expired) begin
                    if (r_retry_cnt < RETRIES_C) begin
                        w_retry        = 1'b1;
                        w_slot1_next   = slot1_encode(1'b1, r_pend_addr);
                        w_slot1_v_next = 1'b1;
                    end else begin
                        w_give_up = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Slots change only on strobes so the framer sees a stable value for the whole frame.
    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            r_slot1       <= '0;
            r_slot1_v     <= 1'b0;
            r_slot2       <= '0;
            r_slot2_v     <= 1'b0;
            r_frame_cnt   <= '0;
            r_retry_cnt   <= '0;
            r_pend_addr   <= '0;
            r_rsp_addr    <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (ac97_strobe) begin
                r_slot1   <= w_slot1_next;
                r_slot1_v <= w_slot1_v_next;
                r_slot2   <= w_slot2_next;
                r_slot2_v <= w_slot2_v_next;
            end
            if (w_pop && !w_head.write) begin
                r_pend_addr <= w_head.addr;
                r_frame_cnt <= '0;
                r_retry_cnt <= '0;
            end
            if (r_state == WAIT_RSP && ac97_strobe) begin
                if (w_match) begin
                    r_rsp_addr    <= r_pend_addr;
                    r_rsp_data    <= ac97_in_slot2[SLOT_W-1 -: DATA_W];
                    r_rsp_timeout <= 1'b0;
                end else if (w_retry) begin
                    r_frame_cnt <= '0;
                    r_retry_cnt <= r_retry_cnt + 1'b1;
                end else if (w_give_up) begin
                    r_rsp_addr    <= r_pend_addr;
                    r_rsp_data    <= '1;
                    r_rsp_timeout <= 1'b1;
                end else begin
                    r_frame_cnt <= w_frame_inc;
                end
            end
        end
    end

    assign cmd_ready            = !w_fifo_full;
    assign rsp_valid            = (r_state == RESP);
    assign rsp_addr             = r_rsp_addr;
    assign rsp_data             = r_rsp_data;
    assign rsp_timeout          = r_rsp_timeout;
    assign ac97_out_slot1       = r_slot1;
    assign ac97_out_slot1_valid = r_slot1_v;
    assign ac97_out_slot2       = r_slot2;
    assign ac97_out_slot2_valid = r_slot2_v;
    assign busy                 = !w_fifo_empty || (r_state != IDLE);

endmodule

// File: tb/tb_ac97_cmd_sequencer.sv
// Bench for ac97_cmd_sequencer: directed frame scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the command engine.
module tb_ac97_cmd_sequencer;

    localparam int CMD_DEPTH      = 8;
    localparam int TIMEOUT_FRAMES = 16;
    localparam int MAX_RETRIES    = 3;
    localparam int FRAME          = 4;

    logic        ac97_bitclk = 1'b0;
    logic        ac97_rst = 1'b0;
    logic        ac97_strobe = 1'b0;
    logic        ac97_codec_ready = 1'b0;
    logic        ac97_in_slot1_valid = 1'b0;
    logic [19:0] ac97_in_slot1 = '0;
    logic        ac97_in_slot2_valid = 1'b0;
    logic [19:0] ac97_in_slot2 = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [6:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [19:0] ac97_out_slot1;
    logic        ac97_out_slot1_valid;
    logic [19:0] ac97_out_slot2;
    logic        ac97_out_slot2_valid;
    logic [3:0]  fifo_level;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    ac97_cmd_sequencer #(
        .CMD_DEPTH      (CMD_DEPTH),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) dut (
        .ac97_bitclk          (ac97_bitclk),
        .ac97_rst             (ac97_rst),
        .ac97_strobe          (ac97_strobe),
        .ac97_codec_ready     (ac97_codec_ready),
        .ac97_in_slot1_valid  (ac97_in_slot1_valid),
        .ac97_in_slot1        (ac97_in_slot1),
        .ac97_in_slot2_valid  (ac97_in_slot2_valid),
        .ac97_in_slot2        (ac97_in_slot2),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_addr             (cmd_addr),
        .cmd_data             (cmd_data),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_addr             (rsp_addr),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .ac97_out_slot1       (ac97_out_slot1),
        .ac97_out_slot1_valid (ac97_out_slot1_valid),
        .ac97_out_slot2       (ac97_out_slot2),
        .ac97_out_slot2_valid (ac97_out_slot2_valid),
        .fifo_level           (fifo_level),
        .busy                 (busy)
    );

    always #5 ac97_bitclk = ~ac97_bitclk;

    int phase = 0;
    always @(negedge ac97_bitclk) begin
        phase = (phase + 1) % FRAME;
        ac97_strobe = (phase == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_q[$];
    bit          m_wait = 0, m_resp = 0, m_rto = 0;
    logic [6:0]  m_paddr = '0, m_raddr = '0;
    logic [15:0] m_rdata = '0;
    int          m_unm = 0, m_retries = 0;
    logic [19:0] m_s1 = '0, m_s2 = '0;
    bit          m_s1v = 0, m_s2v = 0;

    always @(posedge ac97_bitclk or posedge ac97_rst) begin
        bit          push_ok;
        logic [23:0] c;
        if (ac97_rst) begin
            m_q.delete();
            m_wait = 0; m_resp = 0; m_unm = 0; m_retries = 0;
            m_s1 = '0; m_s2 = '0; m_s1v = 0; m_s2v = 0;
        end else begin
            push_ok = cmd_valid && (m_q.size() < CMD_DEPTH);
            if (ac97_strobe) begin
                m_s1 = '0; m_s2 = '0; m_s1v = 0; m_s2v = 0;
            end
            if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (m_wait) begin
                if (ac97_strobe) begin
                    if (ac97_in_slot1_valid && ac97_in_slot2_valid &&
                        7'((ac97_in_slot1 >> 12) & 20'h7F) == m_paddr) begin
                        m_wait = 0; m_resp = 1; m_rto = 0;
                        m_raddr = m_paddr; m_rdata = 16'(ac97_in_slot2 >> 4);
                    end else begin
                        m_unm++;
                        if (m_unm == TIMEOUT_FRAMES) begin
                            if (m_retries < MAX_RETRIES) begin
                                m_retries++; m_unm = 0;
                                m_s1 = (20'h1 << 19) | (20'(m_paddr) << 12); m_s1v = 1;
                            end else begin
                                m_wait = 0; m_resp = 1; m_rto = 1;
                                m_raddr = m_paddr; m_rdata = 16'hFFFF;
                            end
                        end
                    end
                end
            end else if (ac97_strobe && m_q.size() > 0 && ac97_codec_ready) begin
                c = m_q.pop_front();
                m_s1v = 1;
                m_s1  = (c[23] ? 20'h0 : (20'h1 << 19)) | (20'(c[22:16]) << 12);
                if (c[23]) begin
                    m_s2 = 20'(c[15:0]) << 4; m_s2v = 1;
                end else begin
                    m_wait = 1; m_paddr = c[22:16]; m_unm = 0; m_retries = 0;
                end
            end
            if (push_ok) m_q.push_back({cmd_write, cmd_addr, cmd_data});
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge ac97_bitclk);
        #2;
        check("cmp_slot1",   ac97_out_slot1, m_s1);
        check("cmp_slot1_v", ac97_out_slot1_valid, m_s1v);
        check("cmp_slot2",   ac97_out_slot2, m_s2);
        check("cmp_slot2_v", ac97_out_slot2_valid, m_s2v);
        check("cmp_cmd_ready", cmd_ready, m_q.size() < CMD_DEPTH);
        check("cmp_level",   fifo_level, m_q.size());
        check("cmp_busy",    busy, (m_q.size() != 0) || m_wait || m_resp);
        check("cmp_rsp_valid", rsp_valid, m_resp);
        if (m_resp) begin
            check("cmp_rsp_addr", rsp_addr, m_raddr);
            check("cmp_rsp_data", rsp_data, m_rdata);
            check("cmp_rsp_timeout", rsp_timeout, m_rto);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_strobe();
        int n = 0;
        do begin
            @(posedge ac97_bitclk);
            n++;
        end while (!ac97_strobe && n < 4 * FRAME);
        if (!ac97_strobe) begin
            n_total++; n_bad++;
            $display("FAIL strobe_wait: no strobe within %0d cycles", n);
        end
        #1;
    endtask

    task automatic push(input bit wr, input logic [6:0] a, input logic [15:0] d);
        @(negedge ac97_bitclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        @(negedge ac97_bitclk);
        cmd_valid = 1'b0;
    endtask

    task automatic reply(input bit v1, input logic [19:0] s1, input bit v2, input logic [19:0] s2);
        @(negedge ac97_bitclk);
        ac97_in_slot1_valid = v1; ac97_in_slot1 = s1;
        ac97_in_slot2_valid = v2; ac97_in_slot2 = s2;
    endtask

    task automatic rsp_handshake();
        @(negedge ac97_bitclk);
        rsp_ready = 1'b1;
        @(posedge ac97_bitclk);
        #1;
        check("hs_rsp_valid_drop", rsp_valid, 0);
        @(negedge ac97_bitclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [6:0]  t3_addr [8];
    logic [15:0] t3_data [8];

    initial begin
        #1 ac97_rst = 1'b1;
        #1;
        check("rst_slot1_v", ac97_out_slot1_valid, 0);
        check("rst_slot2_v", ac97_out_slot2_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp_valid, rsp_timeout, rsp_addr, rsp_data}, 0);
        repeat (2) @(negedge ac97_bitclk);
        ac97_rst = 1'b0;
        ac97_codec_ready = 1'b1;

        // 1: single write
        push(1, 7'h18, 16'h0808);
        wait_strobe();
        check("t1_slot1", {ac97_out_slot1_valid, ac97_out_slot1}, {1'b1, 20'h18000});
        check("t1_slot2", {ac97_out_slot2_valid, ac97_out_slot2}, {1'b1, 20'h08080});
        wait_strobe();
        check("t1_idle", {ac97_out_slot1_valid, ac97_out_slot2_valid, rsp_valid}, 0);

        // 2: read answered two frames later
        push(0, 7'h7C, 16'h0000);
        wait_strobe();
        check("t2_slot1", {ac97_out_slot1_valid, ac97_out_slot1}, {1'b1, 20'hFC000});
        check("t2_slot2_v", ac97_out_slot2_valid, 0);
        wait_strobe();
        check("t2_no_rsp", rsp_valid, 0);
        reply(1, 20'h7C000, 1, 20'h41440);
        wait_strobe();
        check("t2_rsp", {rsp_valid, rsp_timeout, rsp_addr, rsp_data}, {1'b1, 1'b0, 7'h7C, 16'h4144});
        reply(0, 0, 0, 0);
        rsp_handshake();

        // 3: fill while codec not ready, then drain one per frame
        @(negedge ac97_bitclk) ac97_codec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t3_addr[i] = 7'($urandom_range(0, 127));
            t3_data[i] = 16'($urandom);
            push(1, t3_addr[i], t3_data[i]);
        end
        push(1, 7'h55, 16'hDEAD);
        #1;
        check("t3_level_full", fifo_level, 8);
        check("t3_cmd_ready", cmd_ready, 0);
        wait_strobe();
        check("t3_held", ac97_out_slot1_valid, 0);
        @(negedge ac97_bitclk) ac97_codec_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_strobe();
            check("t3_level", fifo_level, 8 - k);
            check("t3_slot1", {ac97_out_slot1_valid, ac97_out_slot1}, {1'b1, 1'b0, t3_addr[k-1], 12'h000});
            check("t3_slot2", ac97_out_slot2, {t3_data[k-1], 4'h0});
        end
        wait_strobe();
        check("t3_done", {ac97_out_slot1_valid, busy}, 0);

        // 4: read with no reply -> three retries then timeout
        push(0, 7'h26, 16'h0);
        wait_strobe();
        check("t4_issue", ac97_out_slot1, 20'hA6000);
        for (int k = 1; k <= 64; k++) begin
            wait_strobe();
            check("t4_redrive_v", ac97_out_slot1_valid, (k % 16 == 0) && (k < 64));
            if (k % 16 == 0 && k < 64) check("t4_redrive", ac97_out_slot1, 20'hA6000);
            check("t4_rsp_valid", rsp_valid, k == 64);
        end
        check("t4_timeout", {rsp_timeout, rsp_addr, rsp_data}, {1'b1, 7'h26, 16'hFFFF});
        rsp_handshake();

        // 5: wrong echo ignored, right echo accepted, response held under back-pressure
        push(0, 7'h26, 16'h0);
        wait_strobe();
        reply(1, 20'h24000, 1, 20'h12340);
        wait_strobe();
        check("t5_wrong_echo", rsp_valid, 0);
        reply(1, 20'h26000, 1, 20'h000F0);
        wait_strobe();
        check("t5_rsp", {rsp_valid, rsp_timeout, rsp_data}, {1'b1, 1'b0, 16'h000F});
        reply(0, 0, 0, 0);
        push(1, 7'h02, 16'h1234);
        for (int k = 0; k < 5; k++) begin
            wait_strobe();
            check("t5_hold", {rsp_valid, rsp_data, ac97_out_slot1_valid}, {1'b1, 16'h000F, 1'b0});
        end
        rsp_handshake();
        wait_strobe();
        check("t5_write_after", {ac97_out_slot1, ac97_out_slot2}, {20'h02000, 20'h12340});

        // 6: reset while a read is outstanding and writes are queued
        push(0, 7'h26, 16'h0);
        wait_strobe();
        push(1, 7'h10, 16'h1111);
        push(1, 7'h11, 16'h2222);
        push(1, 7'h12, 16'h3333);
        @(negedge ac97_bitclk) ac97_rst = 1'b1;
        #1;
        check("t6_slots", {ac97_out_slot1_valid, ac97_out_slot2_valid, ac97_out_slot1, ac97_out_slot2}, 0);
        check("t6_level", fifo_level, 0);
        check("t6_misc", {busy, rsp_valid, cmd_ready}, 3'b001);
        repeat (2) @(negedge ac97_bitclk);
        ac97_rst = 1'b0;
        push(0, 7'h7E, 16'h0);
        wait_strobe();
        check("t6_issue", ac97_out_slot1, 20'hFE000);
        reply(1, 20'h7E000, 1, 20'hBEEF0);
        wait_strobe();
        check("t6_rsp", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 7'h7E, 16'hBEEF});
        reply(0, 0, 0, 0);
        rsp_handshake();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [19:0] s;
            @(negedge ac97_bitclk);
            cmd_valid        = ($urandom_range(0, 99) < 30);
            cmd_write        = 1'($urandom);
            cmd_addr         = 7'($urandom);
            cmd_data         = 16'($urandom);
            ac97_codec_ready = ($urandom_range(0, 99) < 85);
            rsp_ready        = ($urandom_range(0, 99) < 40);
            r = $urandom_range(0, 99);
            s = 20'($urandom);
            if (r < 40) s[18:12] = m_paddr;
            ac97_in_slot1       = s;
            ac97_in_slot1_valid = (r < 55);
            ac97_in_slot2       = 20'($urandom);
            ac97_in_slot2_valid = ($urandom_range(0, 99) < 90);
        end
        @(negedge ac97_bitclk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge ac97_bitclk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
